// File: rtl/npu_spm_defines.sv
// Shared scratchpad definitions: request geometry, bank indexing types and
// the responder FSM encoding.
package npu_spm_defines;
  localparam int SM_PROCESSING_ELEMENTS = 16;
  localparam int SM_ADDRESS_LEN         = 16;
  localparam int SM_PIGGYBACK_DATA_LEN  = 8;
  localparam int SPM_BANKS              = 16;
  localparam int SPM_BANK_IDX_W         = $clog2(SPM_BANKS);
  localparam int SPM_BANK_ROW_W         = SM_ADDRESS_LEN - SPM_BANK_IDX_W - 2;

  typedef logic [SM_ADDRESS_LEN-1:0] sm_address_t;
  typedef logic [31:0]               sm_data_t;
  typedef logic [3:0]                sm_byte_mask_t;
  typedef logic [SPM_BANK_IDX_W-1:0] spm_bank_idx_t;
  typedef logic [SPM_BANK_ROW_W-1:0] spm_bank_row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESPOND
  } spm_state_t;
endpackage

// File: rtl/spm_bank.sv
// Single-port scratchpad bank: DEPTH x 32 with per-byte write enables and a
// registered read port. Contents are never reset.
module spm_bank
  import npu_spm_defines::*;
#(
  parameter int DEPTH = 1024,
  parameter int ROW_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  sm_byte_mask_t    be,
  input  logic [ROW_W-1:0] row,
  input  sm_data_t         wdata,
  output sm_data_t         rdata
);
  sm_data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[row][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[row];
      end
    end
  end
endmodule

// File: rtl/spm_bank_responder.sv
// Scratchpad responder: serialises a multi-lane request over word-interleaved
// banks. Optional macro SPM_LOAD_BROADCAST_EN lets same-word loads share a grant.
module spm_bank_responder
  import npu_spm_defines::*;
#(
  parameter int LANES      = SM_PROCESSING_ELEMENTS,
  parameter int BANKS      = SPM_BANKS,
  parameter int ADDR_LEN   = SM_ADDRESS_LEN,
  parameter int BANK_DEPTH = 2**(ADDR_LEN-2)/BANKS,
  parameter int PB_LEN     = SM_PIGGYBACK_DATA_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     is_store,
  input  logic [LANES*ADDR_LEN-1:0] addresses,
  input  logic [LANES*32-1:0]      write_data,
  input  logic [LANES*4-1:0]       byte_mask,
  input  logic [LANES-1:0]         mask,
  input  logic [PB_LEN-1:0]        piggyback_data,
  output logic                     sm_ready,
  output logic                     sm_valid,
  output logic [LANES*32-1:0]      sm_read_data,
  output logic [LANES*4-1:0]       sm_byte_mask,
  output logic [LANES-1:0]         sm_mask,
  output logic [PB_LEN-1:0]        sm_piggyback_data
);
  localparam int BI = $clog2(BANKS);
  localparam int WA = ADDR_LEN - 2;
  localparam int RW = WA - BI;

  spm_state_t           state;
  logic                 req_store;
  logic [WA-1:0]        req_word [LANES];
  logic [LANES*32-1:0]  req_wdata;
  logic [LANES*4-1:0]   req_bmask;
  logic [LANES-1:0]     req_mask;
  logic [PB_LEN-1:0]    req_pb;
  logic [LANES-1:0]     pending, grant, served, served_p1;
  logic [BI-1:0]        lane_bank [LANES];

  logic                 bank_en    [BANKS];
  logic [RW-1:0]        bank_row   [BANKS];
  sm_data_t             bank_wdata [BANKS];
  sm_byte_mask_t        bank_be    [BANKS];
  sm_data_t             bank_rdata [BANKS];

  // Byte offsets are the requester's concern; the low address bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addresses;

  wire accept = start && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (accept) begin
      req_store <= is_store;
      req_wdata <= write_data;
      req_bmask <= byte_mask;
      req_mask  <= mask;
      req_pb    <= piggyback_data;
      for (int l = 0; l < LANES; l++) req_word[l] <= addresses[l*ADDR_LEN+2 +: WA];
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) lane_bank[l] = req_word[l][BI-1:0];
  end

  // Per-bank lowest-index pending lane wins the round.
  always_comb begin
    grant = '0;
    for (int l = 0; l < LANES; l++) begin
      grant[l] = pending[l] && (state == ST_ISSUE);
      for (int j = 0; j < l; j++) begin
        if (pending[j] && lane_bank[j] == lane_bank[l]) grant[l] = 1'b0;
      end
    end
  end

`ifdef SPM_LOAD_BROADCAST_EN
  always_comb begin
    served = grant;
    if (!req_store) begin
      for (int l = 0; l < LANES; l++) begin
        for (int j = 0; j < LANES; j++) begin
          if (grant[j] && pending[l] && req_word[j] == req_word[l]) served[l] = 1'b1;
        end
      end
    end
  end
`else
  assign served = grant;
`endif

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      bank_en[b]    = 1'b0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
      bank_be[b]    = '0;
      for (int l = 0; l < LANES; l++) begin
        if (grant[l] && lane_bank[l] == BI'(b)) begin
          bank_en[b]    = 1'b1;
          bank_row[b]   = req_word[l][WA-1:BI];
          bank_wdata[b] = req_wdata[l*32 +: 32];
          bank_be[b]    = req_bmask[l*4 +: 4];
        end
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    spm_bank #(.DEPTH(BANK_DEPTH), .ROW_W(RW)) u_bank (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (req_store),
      .be    (bank_be[b]),
      .row   (bank_row[b]),
      .wdata (bank_wdata[b]),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      pending           <= '0;
      served_p1         <= '0;
      sm_ready          <= 1'b1;
      sm_valid          <= 1'b0;
      sm_read_data      <= '0;
      sm_byte_mask      <= '0;
      sm_mask           <= '0;
      sm_piggyback_data <= '0;
    end else begin
      // Bank read data lands one cycle after the lane's grant.
      served_p1 <= (state == ST_ISSUE && !req_store) ? served : '0;
      for (int l = 0; l < LANES; l++) begin
        if (served_p1[l]) sm_read_data[l*32 +: 32] <= bank_rdata[lane_bank[l]];
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            pending      <= mask;
            sm_read_data <= '0;
            sm_ready     <= 1'b0;
            if (mask != '0) begin
              state <= ST_ISSUE;
            end else begin
              state             <= ST_RESPOND;
              sm_valid          <= 1'b1;
              sm_byte_mask      <= byte_mask;
              sm_mask           <= mask;
              sm_piggyback_data <= piggyback_data;
            end
          end
        end
        ST_ISSUE: begin
          pending <= pending & ~served;
          if ((pending & ~served) == '0) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state             <= ST_RESPOND;
          sm_valid          <= 1'b1;
          sm_byte_mask      <= req_bmask;
          sm_mask           <= req_mask;
          sm_piggyback_data <= req_pb;
        end
        default: begin
          state    <= ST_IDLE;
          sm_valid <= 1'b0;
          sm_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
